// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and constants for the IF / MEM-stage RAM port arbiter.
// Holds the owner encoding, the reset level, grant vector indices and the default RAM word.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    localparam logic RST_ENABLE = 1'b0;

    localparam int BE_W  = 4;
    localparam int LAT_W = 3;

    localparam int GNT_IF = 0;
    localparam int GNT_D  = 1;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Window is open while idle or in the response cycle of the read in flight.
    function automatic logic window_is_open(input logic [LAT_W-1:0] lat);
        return lat <= LAT_W'(1);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the fetch and data ports.
// if_pref breaks a tie towards IF (starvation flag or round-robin last-grant).
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic       window_open,
    input  logic       if_req,
    input  logic       d_req,
    input  logic       if_pref,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (window_open) begin
            if (if_req && d_req) begin
                if (if_pref) begin
                    gnt[GNT_IF] = 1'b1;
                end else begin
                    gnt[GNT_D] = 1'b1;
                end
            end else begin
                gnt[GNT_IF] = if_req;
                gnt[GNT_D]  = d_req;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between the IF fetch port and the MEM load/store port.
// Define MEM_ARB_RR_EN for round-robin ties; otherwise data wins with an IF starvation guard.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    input  logic [BE_W-1:0]   d_be_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [BE_W-1:0]   mem_be_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_if_o,
    output logic              stall_mem_o
);

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT);

    logic [LAT_W-1:0] lat_cnt_reg, lat_cnt_next;
    owner_e           owner_reg, owner_next;

    logic       run;
    logic       window_open;
    logic       if_pref;
    logic [1:0] gnt;
    logic       d_store;
    logic       rd_gnt;
    logic       resp_cycle;

    // Everything is held quiet while reset is asserted, even with requests present.
    assign run         = (arst_n != RST_ENABLE);
    assign window_open = run && window_is_open(lat_cnt_reg);

`ifdef MEM_ARB_RR_EN
    logic last_d_reg, last_d_next;

    assign if_pref = last_d_reg;

    always_comb begin
        last_d_next = last_d_reg;
        if (d_gnt_o) begin
            last_d_next = 1'b1;
        end else if (if_gnt_o) begin
            last_d_next = 1'b0;
        end
    end

    // Reset as "IF granted last" so the data port takes the first tie.
    always_ff @(posedge clk) begin
        if (arst_n == RST_ENABLE) begin
            last_d_reg <= 1'b0;
        end else begin
            last_d_reg <= last_d_next;
        end
    end
`else
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_cnt_reg, starve_cnt_next;

    assign if_pref = (starve_cnt_reg == STARVE_LIM);

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!if_req_i || if_gnt_o) begin
            starve_cnt_next = '0;
        end else if (d_gnt_o && (starve_cnt_reg != STARVE_LIM)) begin
            starve_cnt_next = starve_cnt_reg + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (arst_n == RST_ENABLE) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end
`endif

    mem_arb_pick u_pick (
        .window_open (window_open),
        .if_req      (if_req_i),
        .d_req       (d_req_i),
        .if_pref     (if_pref),
        .gnt         (gnt)
    );

    assign if_gnt_o = gnt[GNT_IF];
    assign d_gnt_o  = gnt[GNT_D];
    assign d_store  = d_gnt_o & d_we_i;
    assign rd_gnt   = if_gnt_o | (d_gnt_o & ~d_we_i);

    assign mem_en_o    = if_gnt_o | d_gnt_o;
    assign mem_we_o    = d_store;
    assign mem_addr_o  = d_gnt_o ? d_addr_i : (if_gnt_o ? if_addr_i : '0);
    assign mem_wdata_o = d_store ? d_wdata_i : '0;

    // Reads always fetch the full word; stores pass their lane enables through.
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_be
        assign mem_be_o[gi] = mem_en_o & (~d_store | d_be_i[gi]);
    end

    assign resp_cycle  = run && (lat_cnt_reg == LAT_W'(1));
    assign if_rvalid_o = resp_cycle && (owner_reg == OWN_IF);
    assign d_rvalid_o  = resp_cycle && (owner_reg == OWN_D);
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : DATA_W'(ZERO_WORD);
    assign d_rdata_o   = d_rvalid_o  ? mem_rdata_i : DATA_W'(ZERO_WORD);

    assign stall_if_o  = run & if_req_i & ~if_gnt_o;
    assign stall_mem_o = run & ((d_req_i & ~d_gnt_o) |
                                ((owner_reg == OWN_D) && (lat_cnt_reg > LAT_W'(1))));

    // A new read in the response cycle reloads the counter instead of letting it expire.
    always_comb begin
        lat_cnt_next = lat_cnt_reg;
        owner_next   = owner_reg;
        if (rd_gnt) begin
            lat_cnt_next = LAT_LOAD;
            owner_next   = if_gnt_o ? OWN_IF : OWN_D;
        end else if (lat_cnt_reg != '0) begin
            lat_cnt_next = lat_cnt_reg - LAT_W'(1);
            if (lat_cnt_reg == LAT_W'(1)) begin
                owner_next = OWN_NONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (arst_n == RST_ENABLE) begin
            lat_cnt_reg <= '0;
            owner_reg   <= OWN_NONE;
        end else begin
            lat_cnt_reg <= lat_cnt_next;
            owner_reg   <= owner_next;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: timestamp-based reference model plus a RAM model.
// Grants are checked each cycle; read responses are queued and checked by a separate monitor.
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MEM_LAT    = 3;
    localparam int STARVE_MAX = 4;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    typedef struct packed {
        int          due;
        logic [31:0] data;
    } resp_t;

    logic              clk = 1'b0;
    logic              arst_n = 1'b0;
    logic              if_req_i = 1'b0;
    logic [ADDR_W-1:0] if_addr_i = '0;
    logic              if_gnt_o, if_rvalid_o;
    logic [DATA_W-1:0] if_rdata_o;
    logic              d_req_i = 1'b0, d_we_i = 1'b0;
    logic [ADDR_W-1:0] d_addr_i = '0;
    logic [DATA_W-1:0] d_wdata_i = '0;
    logic [3:0]        d_be_i = '0;
    logic              d_gnt_o, d_rvalid_o;
    logic [DATA_W-1:0] d_rdata_o;
    logic              mem_en_o, mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [3:0]        mem_be_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              stall_if_o, stall_mem_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic rst_assert = 1'b1;

    txn_t  if_q[$];
    txn_t  d_q[$];
    resp_t exp_if[$];
    resp_t exp_d[$];
    logic [31:0] shadow [256];

    int   m_last_rd = -1000;
    int   m_d_due   = -1;
    int   m_starve  = 0;
    logic m_last_d  = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .arst_n(arst_n),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_be_i(d_be_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i),
        .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'h5A00_0000 ^ (i * 32'h0001_0103);
    endfunction

    // RAM model: word array with a MEM_LAT-deep read pipeline; garbage when no read was issued.
    logic [31:0] ram [256];
    logic [31:0] rd_pipe [MEM_LAT];
    assign mem_rdata_i = rd_pipe[MEM_LAT-1];

    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
        end else if (mem_en_o && mem_we_o) begin
            for (int b = 0; b < 4; b++)
                if (mem_be_o[b]) ram[mem_addr_o[9:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
        rd_pipe[0] <= (mem_en_o && !mem_we_o) ? ram[mem_addr_o[9:2]] : (32'hBAD0_0000 ^ cyc);
        for (int k = 1; k < MEM_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_if(input logic [31:0] addr);
        txn_t t;
        t.we = 1'b0; t.addr = addr; t.wdata = '0; t.be = 4'hF;
        if_q.push_back(t);
    endtask

    task automatic push_d(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata; t.be = be;
        d_q.push_back(t);
    endtask

    task automatic push_rand_d();
        logic [31:0] a;
        a = {22'd0, 8'($urandom_range(0, 31)), 2'b00};
        push_d($urandom_range(0, 2) == 0, a, $urandom, 4'($urandom));
    endtask

    // One clock cycle: drive inputs, predict this cycle's arbitration, compare, update model.
    task automatic step();
        logic eg_if, eg_d, open, exp_stall_mem;
        int idx;
        @(posedge clk);
        #1;
        arst_n    = ~rst_assert;
        if_req_i  = (if_q.size() > 0);
        if_addr_i = if_req_i ? if_q[0].addr : '0;
        d_req_i   = (d_q.size() > 0);
        d_we_i    = d_req_i ? d_q[0].we : 1'b0;
        d_addr_i  = d_req_i ? d_q[0].addr : '0;
        d_wdata_i = d_req_i ? d_q[0].wdata : '0;
        d_be_i    = d_req_i ? d_q[0].be : '0;
        #1;
        eg_if = 1'b0;
        eg_d  = 1'b0;
        if (!arst_n) begin
            exp_if.delete();
            exp_d.delete();
            m_last_rd = -1000; m_d_due = -1; m_starve = 0; m_last_d = 1'b0;
            chk("rst_gnt_en_we", {if_gnt_o, d_gnt_o, mem_en_o, mem_we_o}, 0);
            chk("rst_mem_addr", mem_addr_o, 0);
            chk("rst_mem_wdata", mem_wdata_o, 0);
            chk("rst_mem_be", mem_be_o, 0);
            chk("rst_stall", {stall_if_o, stall_mem_o}, 0);
            chk("rst_rvalid", {if_rvalid_o, d_rvalid_o}, 0);
            chk("rst_rdata", if_rdata_o | d_rdata_o, 0);
            return;
        end
        open = (cyc - m_last_rd) >= MEM_LAT;
        if (open) begin
            if (if_req_i && d_req_i) begin
`ifdef MEM_ARB_RR_EN
                if (m_last_d) eg_if = 1'b1; else eg_d = 1'b1;
`else
                if (m_starve == STARVE_MAX) eg_if = 1'b1; else eg_d = 1'b1;
`endif
            end else begin
                eg_if = if_req_i;
                eg_d  = d_req_i;
            end
        end
        exp_stall_mem = (d_req_i && !eg_d) || (cyc < m_d_due);
        chk("if_gnt", if_gnt_o, eg_if);
        chk("d_gnt", d_gnt_o, eg_d);
        chk("mem_en", mem_en_o, eg_if | eg_d);
        chk("stall_if", stall_if_o, if_req_i && !eg_if);
        chk("stall_mem", stall_mem_o, exp_stall_mem);
        if (eg_if) begin
            idx = int'(if_q[0].addr[9:2]);
            chk("if_mem_cmd", {mem_we_o, mem_be_o, mem_addr_o}, {1'b0, 4'hF, if_q[0].addr});
            exp_if.push_back('{due: cyc + MEM_LAT, data: shadow[idx]});
            $display("cyc %0d IF  rd addr %08h", cyc, if_q[0].addr);
            m_last_rd = cyc;
            void'(if_q.pop_front());
        end
        if (eg_d) begin
            idx = int'(d_q[0].addr[9:2]);
            if (d_q[0].we) begin
                chk("d_st_cmd", {mem_we_o, mem_be_o, mem_addr_o}, {1'b1, d_q[0].be, d_q[0].addr});
                chk("d_st_wdata", mem_wdata_o, d_q[0].wdata);
                for (int b = 0; b < 4; b++)
                    if (d_q[0].be[b]) shadow[idx][8*b +: 8] = d_q[0].wdata[8*b +: 8];
                $display("cyc %0d D   wr addr %08h data %08h be %h", cyc, d_q[0].addr, d_q[0].wdata, d_q[0].be);
            end else begin
                chk("d_ld_cmd", {mem_we_o, mem_be_o, mem_addr_o}, {1'b0, 4'hF, d_q[0].addr});
                exp_d.push_back('{due: cyc + MEM_LAT, data: shadow[idx]});
                $display("cyc %0d D   rd addr %08h", cyc, d_q[0].addr);
                m_last_rd = cyc;
                m_d_due   = cyc + MEM_LAT;
            end
            void'(d_q.pop_front());
        end
        if (!if_req_i || eg_if) m_starve = 0;
        else if (eg_d && m_starve < STARVE_MAX) m_starve++;
        if (eg_d) m_last_d = 1'b1;
        else if (eg_if) m_last_d = 1'b0;
    endtask

    task automatic run_idle(input int extra);
        int n = 0;
        while ((if_q.size() > 0 || d_q.size() > 0 || exp_if.size() > 0 || exp_d.size() > 0) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) chk("idle_timeout", 1, 0);
        repeat (extra) step();
    endtask

    // Response monitor: decoupled from stimulus, pops an expectation whenever rvalid shows up.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (if_rvalid_o) begin
                if (exp_if.size() == 0) chk("if_rvalid_unexpected", 1, 0);
                else begin
                    e = exp_if.pop_front();
                    chk("if_resp_cycle", cyc, e.due);
                    chk("if_rdata", if_rdata_o, e.data);
                end
            end else begin
                if (exp_if.size() > 0 && exp_if[0].due <= cyc) begin
                    chk("if_rvalid_missing", 0, 1);
                    void'(exp_if.pop_front());
                end
                chk("if_rdata_idle", if_rdata_o, 0);
            end
            if (d_rvalid_o) begin
                if (exp_d.size() == 0) chk("d_rvalid_unexpected", 1, 0);
                else begin
                    e = exp_d.pop_front();
                    chk("d_resp_cycle", cyc, e.due);
                    chk("d_rdata", d_rdata_o, e.data);
                end
            end else begin
                if (exp_d.size() > 0 && exp_d[0].due <= cyc) begin
                    chk("d_rvalid_missing", 0, 1);
                    void'(exp_d.pop_front());
                end
                chk("d_rdata_idle", d_rdata_o, 0);
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
        rst_assert = 1'b1;
        repeat (3) step();
        rst_assert = 1'b0;

        push_if(32'h100);
        run_idle(2);

        push_d(1'b0, 32'h200, 32'h0, 4'hF);
        push_if(32'h300);
        run_idle(2);

        repeat (8) push_d(1'b0, {22'd0, 8'($urandom_range(0, 255)), 2'b00}, 32'h0, 4'hF);
        push_if(32'h104);
        run_idle(2);

        push_d(1'b0, 32'h40, 32'h0, 4'hF);
        push_d(1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF);
        push_d(1'b0, 32'h40, 32'h0, 4'hF);
        run_idle(2);

        for (int i = 0; i < 700; i++) begin
            int p_if, p_d;
            p_if = (i < 350) ? 40 : 90;
            p_d  = (i < 350) ? 50 : 90;
            if (if_q.size() < 2 && $urandom_range(0, 99) < p_if)
                push_if({22'd0, 8'($urandom_range(0, 31)), 2'b00});
            if (d_q.size() < 2 && $urandom_range(0, 99) < p_d)
                push_rand_d();
            step();
        end
        run_idle(2);

        // Reset while a load is two cycles from its response; an IF request waits across it.
        push_d(1'b0, 32'h80, 32'h0, 4'hF);
        n = 0;
        while (d_q.size() > 0 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) chk("rst_load_timeout", 1, 0);
        push_if(32'h84);
        step();
        rst_assert = 1'b1;
        repeat (2) step();
        rst_assert = 1'b0;
        run_idle(6);

        chk("drain_if", exp_if.size(), 0);
        chk("drain_d", exp_d.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
